// File: rtl/alu_instr_sequencer_if.sv
// Control bundle between the instruction sequencer (master) and the datapath (slave).
// Carries the run request, the IR contents and every register-transfer strobe.
interface alu_instr_sequencer_if;
    logic        run;
    logic [31:0] ir;

    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin, Yin;
    logic        Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic [15:0] Rin;
    logic [15:0] Rout;

    logic        ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, MUL, DIV, NEG, NOT;
    logic        busy;
    logic        illegal;

    modport master (
        input  run, ir,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin, Yin,
        output Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Rin, Rout,
        output ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, MUL, DIV, NEG, NOT,
        output busy, illegal
    );

    modport slave (
        output run, ir,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin, Yin,
        input  Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Rin, Rout,
        input  ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, MUL, DIV, NEG, NOT,
        input  busy, illegal
    );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Hardwired fetch/decode/execute sequencer for register-to-register ALU instructions.
// Define MULDIV_EN to enable the MUL/DIV sequence; otherwise those opcodes are illegal.
module alu_instr_sequencer (
    input  logic                    clock,
    input  logic                    clear,
    alu_instr_sequencer_if.master   bus
);

    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;
    typedef enum logic [1:0] {CLS_ALU3, CLS_MULDIV, CLS_UNARY, CLS_ILLEGAL} class_t;

    state_t      state_q, state_d;
    class_t      opClass;
    logic        lastStep;
    logic        opStrobe;
    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc;
    logic [15:0] raSel, rbSel, rcSel;
    logic        unusedIrBits;

    assign opcode       = bus.ir[31:27];
    assign ra           = bus.ir[26:23];
    assign rb           = bus.ir[22:19];
    assign rc           = bus.ir[18:15];
    assign unusedIrBits = ^bus.ir[14:0];
    assign raSel        = 16'd1 << ra;
    assign rbSel        = 16'd1 << rb;
    assign rcSel        = 16'd1 << rc;

    always_comb begin
        opClass = CLS_ILLEGAL;
        case (opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: opClass = CLS_ALU3;
`ifdef MULDIV_EN
            5'b01111, 5'b10000:                     opClass = CLS_MULDIV;
`endif
            5'b10001, 5'b10010:                     opClass = CLS_UNARY;
            default:                                opClass = CLS_ILLEGAL;
        endcase
    end

    // Each instruction class finishes on a different execute step.
    always_comb begin
        lastStep = 1'b0;
        case (state_q)
            T3:      lastStep = (opClass == CLS_ILLEGAL);
            T4:      lastStep = (opClass == CLS_UNARY);
            T5:      lastStep = (opClass == CLS_ALU3);
            T6:      lastStep = 1'b1;
            default: lastStep = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.run ? T0 : IDLE;
            T0:      state_d = T1;
            T1:      state_d = T2;
            T2:      state_d = T3;
            T3:      state_d = T4;
            T4:      state_d = T5;
            T5:      state_d = T6;
            T6:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (lastStep) begin
            state_d = bus.run ? T0 : IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes depend only on state and IR; clear blanks them in the same cycle.
    always_comb begin
        bus.PCout     = 1'b0;
        bus.PCin      = 1'b0;
        bus.IncPC     = 1'b0;
        bus.MARin     = 1'b0;
        bus.MDRin     = 1'b0;
        bus.MDRout    = 1'b0;
        bus.MDMuxread = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zlowin    = 1'b0;
        bus.Zhighin   = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.Zhighout  = 1'b0;
        bus.HIin      = 1'b0;
        bus.LOin      = 1'b0;
        bus.Rin       = 16'd0;
        bus.Rout      = 16'd0;
        bus.busy      = 1'b0;
        bus.illegal   = 1'b0;
        opStrobe      = 1'b0;
        if (!clear) begin
            bus.busy = (state_q != IDLE);
            case (state_q)
                T0: begin
                    bus.PCout  = 1'b1;
                    bus.MARin  = 1'b1;
                    bus.IncPC  = 1'b1;
                    bus.Zlowin = 1'b1;
                end
                T1: begin
                    bus.Zlowout   = 1'b1;
                    bus.PCin      = 1'b1;
                    bus.MDMuxread = 1'b1;
                    bus.MDRin     = 1'b1;
                end
                T2: begin
                    bus.MDRout = 1'b1;
                    bus.IRin   = 1'b1;
                end
                T3: begin
                    case (opClass)
                        CLS_ALU3, CLS_MULDIV: begin
                            bus.Rout = rbSel;
                            bus.Yin  = 1'b1;
                        end
                        CLS_UNARY: begin
                            bus.Rout   = rbSel;
                            opStrobe   = 1'b1;
                            bus.Zlowin = 1'b1;
                        end
                        default: bus.illegal = 1'b1;
                    endcase
                end
                T4: begin
                    case (opClass)
                        CLS_ALU3: begin
                            bus.Rout   = rcSel;
                            opStrobe   = 1'b1;
                            bus.Zlowin = 1'b1;
                        end
                        CLS_MULDIV: begin
                            bus.Rout    = rcSel;
                            opStrobe    = 1'b1;
                            bus.Zlowin  = 1'b1;
`ifdef MULDIV_EN
                            bus.Zhighin = 1'b1;
`endif
                        end
                        CLS_UNARY: begin
                            bus.Zlowout = 1'b1;
                            bus.Rin     = raSel;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opClass)
                        CLS_ALU3: begin
                            bus.Zlowout = 1'b1;
                            bus.Rin     = raSel;
                        end
                        CLS_MULDIV: begin
`ifdef MULDIV_EN
                            bus.Zlowout = 1'b1;
                            bus.LOin    = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
                T6: begin
`ifdef MULDIV_EN
                    bus.Zhighout = 1'b1;
                    bus.HIin     = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.ADD  = opStrobe && (opcode == 5'b00011);
    assign bus.SUB  = opStrobe && (opcode == 5'b00100);
    assign bus.AND  = opStrobe && (opcode == 5'b00101);
    assign bus.OR   = opStrobe && (opcode == 5'b00110);
    assign bus.ROR  = opStrobe && (opcode == 5'b00111);
    assign bus.ROL  = opStrobe && (opcode == 5'b01000);
    assign bus.SHR  = opStrobe && (opcode == 5'b01001);
    assign bus.SHRA = opStrobe && (opcode == 5'b01010);
    assign bus.SHL  = opStrobe && (opcode == 5'b01011);
    assign bus.NEG  = opStrobe && (opcode == 5'b10001);
    assign bus.NOT  = opStrobe && (opcode == 5'b10010);
`ifdef MULDIV_EN
    assign bus.DIV  = opStrobe && (opcode == 5'b01111);
    assign bus.MUL  = opStrobe && (opcode == 5'b10000);
`else
    assign bus.DIV  = 1'b0;
    assign bus.MUL  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench for alu_instr_sequencer: directed table, hand sequences and
// randomized instruction streams checked cycle by cycle against a step-list model.
module tb_alu_instr_sequencer;

    typedef struct packed {
        logic        busy;
        logic        illegal;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [12:0] ops;
        logic [14:0] strb;
    } snap_t;

    typedef struct {
        logic [31:0] ir;
        int          len;
        logic [12:0] ops;
        logic [15:0] rinOr;
        logic        ill;
    } vec_t;

    localparam logic [14:0] M_PCOUT = 15'd1 << 0;
    localparam logic [14:0] M_PCIN  = 15'd1 << 1;
    localparam logic [14:0] M_INCPC = 15'd1 << 2;
    localparam logic [14:0] M_MARIN = 15'd1 << 3;
    localparam logic [14:0] M_MDRIN = 15'd1 << 4;
    localparam logic [14:0] M_MDROUT = 15'd1 << 5;
    localparam logic [14:0] M_MDMUX = 15'd1 << 6;
    localparam logic [14:0] M_IRIN  = 15'd1 << 7;
    localparam logic [14:0] M_YIN   = 15'd1 << 8;
    localparam logic [14:0] M_ZLIN  = 15'd1 << 9;
    localparam logic [14:0] M_ZHIN  = 15'd1 << 10;
    localparam logic [14:0] M_ZLOUT = 15'd1 << 11;
    localparam logic [14:0] M_ZHOUT = 15'd1 << 12;
    localparam logic [14:0] M_HIIN  = 15'd1 << 13;
    localparam logic [14:0] M_LOIN  = 15'd1 << 14;

`ifdef MULDIV_EN
    localparam bit MULDIV_ON = 1'b1;
`else
    localparam bit MULDIV_ON = 1'b0;
`endif

    logic  clock;
    logic  clear;
    int    checks = 0;
    int    errors = 0;
    snap_t expSeq[$];
    vec_t  vecs[9];
    logic [4:0] legalOps[13];

    alu_instr_sequencer_if bus ();

    alu_instr_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic snap_t sample();
        snap_t s;
        s.busy    = bus.busy;
        s.illegal = bus.illegal;
        s.rin     = bus.Rin;
        s.rout    = bus.Rout;
        s.ops     = {bus.NOT, bus.NEG, bus.DIV, bus.MUL, bus.SHL, bus.SHRA, bus.SHR,
                     bus.ROL, bus.ROR, bus.OR, bus.AND, bus.SUB, bus.ADD};
        s.strb    = {bus.LOin, bus.HIin, bus.Zhighout, bus.Zlowout, bus.Zhighin, bus.Zlowin,
                     bus.Yin, bus.IRin, bus.MDMuxread, bus.MDRout, bus.MDRin, bus.MARin,
                     bus.IncPC, bus.PCin, bus.PCout};
        return s;
    endfunction

    function automatic snap_t mk(logic [14:0] strb, logic [15:0] rin, logic [15:0] rout,
                                 logic [12:0] ops, logic ill);
        snap_t s;
        s.busy = 1'b1; s.illegal = ill; s.rin = rin; s.rout = rout; s.ops = ops; s.strb = strb;
        return s;
    endfunction

    // Reference: the instruction expands into a list of per-cycle strobe sets.
    function automatic void buildSeq(input logic [31:0] instr);
        int          opc, opIdx, kind;
        logic [15:0] raBit, rbBit, rcBit;
        logic [12:0] opBit;
        opc   = int'(instr[31:27]);
        raBit = 16'd1 << instr[26:23];
        rbBit = 16'd1 << instr[22:19];
        rcBit = 16'd1 << instr[18:15];
        opIdx = 0;
        kind  = 3;
        if (opc >= 3 && opc <= 11) begin kind = 0; opIdx = opc - 3; end
        else if (MULDIV_ON && opc == 15) begin kind = 1; opIdx = 10; end
        else if (MULDIV_ON && opc == 16) begin kind = 1; opIdx = 9; end
        else if (opc == 17) begin kind = 2; opIdx = 11; end
        else if (opc == 18) begin kind = 2; opIdx = 12; end
        opBit = 13'd1 << opIdx;
        expSeq.delete();
        expSeq.push_back(mk(M_PCOUT | M_MARIN | M_INCPC | M_ZLIN, 0, 0, 0, 0));
        expSeq.push_back(mk(M_ZLOUT | M_PCIN | M_MDMUX | M_MDRIN, 0, 0, 0, 0));
        expSeq.push_back(mk(M_MDROUT | M_IRIN, 0, 0, 0, 0));
        case (kind)
            0: begin
                expSeq.push_back(mk(M_YIN, 0, rbBit, 0, 0));
                expSeq.push_back(mk(M_ZLIN, 0, rcBit, opBit, 0));
                expSeq.push_back(mk(M_ZLOUT, raBit, 0, 0, 0));
            end
            1: begin
                expSeq.push_back(mk(M_YIN, 0, rbBit, 0, 0));
                expSeq.push_back(mk(M_ZLIN | M_ZHIN, 0, rcBit, opBit, 0));
                expSeq.push_back(mk(M_ZLOUT | M_LOIN, 0, 0, 0, 0));
                expSeq.push_back(mk(M_ZHOUT | M_HIIN, 0, 0, 0, 0));
            end
            2: begin
                expSeq.push_back(mk(M_ZLIN, 0, rbBit, opBit, 0));
                expSeq.push_back(mk(M_ZLOUT, raBit, 0, 0, 0));
            end
            default: expSeq.push_back(mk(15'd0, 0, 0, 0, 1));
        endcase
    endfunction

    task automatic checkOutput(input string name, input snap_t want);
        snap_t got;
        got = sample();
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic checkVal(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Drives one instruction starting at its T0 cycle; run is ignored except on the final step.
    task automatic applyStimulus(input logic [31:0] instr, input bit runAfter);
        int n;
        buildSeq(instr);
        n = expSeq.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (k == 0) bus.ir = instr;
            #1;
            checkOutput($sformatf("step%0d_ir%h", k, instr), expSeq[k]);
            bus.run = (k == n - 1) ? runAfter : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic measureVector(input int idx);
        int          cycles;
        logic [12:0] opsOr;
        logic [15:0] rinOr;
        logic        illOr;
        bit          done;
        cycles = 0; opsOr = '0; rinOr = '0; illOr = 1'b0; done = 1'b0;
        bus.ir  = vecs[idx].ir;
        bus.run = 1'b1;
        while (!done) begin
            @(negedge clock);
            #1;
            if (bus.busy) begin
                cycles++;
                opsOr = opsOr | sample().ops;
                rinOr = rinOr | bus.Rin;
                illOr = illOr | bus.illegal;
                bus.run = 1'b0;
                if (cycles > 20) begin
                    done = 1'b1;
                    checkVal($sformatf("vec%0d_timeout", idx), 64'(cycles), 64'(vecs[idx].len));
                    clear = 1'b1;
                    @(negedge clock);
                    clear = 1'b0;
                end
            end else begin
                done = 1'b1;
            end
        end
        checkVal($sformatf("vec%0d_len", idx), 64'(cycles), 64'(vecs[idx].len));
        checkVal($sformatf("vec%0d_ops", idx), 64'(opsOr), 64'(vecs[idx].ops));
        checkVal($sformatf("vec%0d_rin", idx), 64'(rinOr), 64'(vecs[idx].rinOr));
        checkVal($sformatf("vec%0d_illegal", idx), 64'(illOr), 64'(vecs[idx].ill));
    endtask

    initial begin
        logic [31:0] r;
        logic [4:0]  opc;
        bit          runAfter;
        int          nIdle;

        clear   = 1'b1;
        bus.run = 1'b0;
        bus.ir  = 32'd0;
        legalOps = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                     5'd15, 5'd16, 5'd17, 5'd18};

        vecs[0] = '{32'h18918000, 6, 13'd1 << 0, 16'h0002, 1'b0};
        vecs[1] = '{32'h8BB00000, 5, 13'd1 << 11, 16'h0080, 1'b0};
        vecs[2] = '{32'hF8000000, 4, 13'd0, 16'h0000, 1'b1};
        vecs[3] = '{{5'b00100, 4'd15, 4'd0, 4'd15, 15'd0}, 6, 13'd1 << 1, 16'h8000, 1'b0};
        vecs[4] = '{{5'b10010, 4'd3, 4'd3, 19'd0}, 5, 13'd1 << 12, 16'h0008, 1'b0};
        vecs[5] = '{{5'b01011, 4'd0, 4'd9, 4'd12, 15'h7fff}, 6, 13'd1 << 8, 16'h0001, 1'b0};
        vecs[6] = '{{5'b01100, 27'h5555555}, 4, 13'd0, 16'h0000, 1'b1};
`ifdef MULDIV_EN
        vecs[7] = '{32'h80228000, 7, 13'd1 << 9, 16'h0000, 1'b0};
        vecs[8] = '{32'h78000000, 7, 13'd1 << 10, 16'h0000, 1'b0};
`else
        vecs[7] = '{32'h80228000, 4, 13'd0, 16'h0000, 1'b1};
        vecs[8] = '{32'h78000000, 4, 13'd0, 16'h0000, 1'b1};
`endif

        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("resetOutputs", '0);
        clear = 1'b0;
        @(negedge clock);
        #1;
        checkOutput("idleAfterReset", '0);

        for (int i = 0; i < 9; i++) measureVector(i);

        // ADD back-to-back, then clear during T4 of the following ADD.
        bus.ir  = 32'h18918000;
        bus.run = 1'b1;
        @(negedge clock); #1; checkVal("addT0_PCout", 64'(bus.PCout), 1);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock); #1;
        checkVal("addT3_Rout", 64'(bus.Rout), 64'h0004);
        checkVal("addT3_Yin", 64'(bus.Yin), 1);
        @(negedge clock); #1;
        checkVal("addT4_Rout", 64'(bus.Rout), 64'h0008);
        checkVal("addT4_ADD", 64'(bus.ADD), 1);
        checkVal("addT4_Zlowin", 64'(bus.Zlowin), 1);
        @(negedge clock); #1;
        checkVal("addT5_Zlowout", 64'(bus.Zlowout), 1);
        checkVal("addT5_Rin", 64'(bus.Rin), 64'h0002);
        @(negedge clock); #1;
        checkVal("addNextT0_PCout", 64'(bus.PCout), 1);
        checkVal("addNextT0_busy", 64'(bus.busy), 1);
        repeat (4) @(negedge clock);
        #1;
        checkVal("add2T4_Zlowin", 64'(bus.Zlowin), 1);
        clear = 1'b1;
        #1;
        checkOutput("clearForcesZero", '0);
        @(negedge clock); #1;
        checkOutput("clearHeldRunHigh", '0);
        @(negedge clock);
        clear   = 1'b0;
        bus.run = 1'b0;
        #1;
        checkOutput("idleAfterMidClear", '0);
        @(negedge clock); #1;
        checkOutput("stillIdleNoR1", '0);

        bus.run = 1'b1;
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            if ($urandom_range(0, 9) < 8) opc = legalOps[$urandom_range(0, 12)];
            else opc = 5'($urandom());
            runAfter = (i != 59) && ($urandom_range(0, 3) != 0);
            applyStimulus({opc, r[26:0]}, runAfter);
            if (!runAfter) begin
                nIdle = $urandom_range(1, 3);
                for (int j = 0; j < nIdle; j++) begin
                    @(negedge clock); #1;
                    checkOutput("idleGap", '0);
                    bus.run = (j == nIdle - 1) && (i != 59);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_instr_sequencer.md
# alu_instr_sequencer

Hardwired control sequencer that drives the datapath's register-transfer control inputs for one register-to-register ALU instruction at a time. It generates fetch steps T0–T2, decodes the instruction register contents, and issues execute steps T3–T6. It sits directly upstream of the datapath: every load/drive/ALU-select strobe the datapath consumes comes from this block. It returns to fetch, or to idle, after each instruction.

## Interface
- MULDIV_EN (macro, not a parameter): see Configuration.
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  synchronous, active-high reset.
- run  in  1  start/continue request, sampled in IDLE and on the final step of each instruction.
- ir  in  32  datapath IR contents, stable from T3 to the end of the instruction.
  - opcode = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15].
- PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin, Yin  out  1 each  datapath strobes.
- Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin  out  1 each  datapath strobes.
- Rin  out  16  one-hot general-register load select (bit n = RnIn).
- Rout  out  16  one-hot general-register drive select (bit n = RnOut).
- ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, MUL, DIV, NEG, NOT  out  1 each  ALU op select, at most one high.
- busy  out  1  high in every state except IDLE.
- illegal  out  1  one-cycle pulse in T3 when the opcode is unsupported.

## Operation
- Opcode map:
  - Three-register ops: 00011 ADD, 00100 SUB, 00101 AND, 00110 OR, 00111 ROR, 01000 ROL, 01001 SHR, 01010 SHRA, 01011 SHL.
  - Multiply/divide: 01111 DIV, 10000 MUL.
  - Two-register ops: 10001 NEG, 10010 NOT.
  - All other opcodes are illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- IDLE: all outputs 0; go to T0 when run=1.
- Fetch steps (all instructions):
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1: Zlowout, PCin, MDMuxread, MDRin.
  - T2: MDRout, IRin.
- Three-register op:
  - T3: Rout[rb], Yin.
  - T4: Rout[rc], op, Zlowin.
  - T5: Zlowout, Rin[ra]; instruction ends.
- MUL/DIV:
  - T3: Rout[rb], Yin.
  - T4: Rout[rc], op, Zlowin, Zhighin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin; instruction ends.
- NEG/NOT:
  - T3: Rout[rb], op, Zlowin.
  - T4: Zlowout, Rin[ra]; instruction ends.
- Illegal opcode:
  - T3: illegal=1 only; no register, HI, LO or Z write; instruction ends.
- End of instruction: go to T0 if run=1, otherwise IDLE.
- Rin and Rout are always one-hot or zero. ra, rb and rc fields are 4 bits, so no out-of-range case exists; ra=rb is legal.

## Timing
- Outputs are a combinational decode of the state register and ir only. There is no combinational path from run to any output.
- Each strobe is high for exactly one clock cycle. The datapath captures on the rising edge that ends the step.
- Latency from the first T0 to the completing edge:
  - three-register op: 6 cycles;
  - MUL/DIV: 7 cycles;
  - NEG/NOT: 5 cycles;
  - illegal opcode: 4 cycles.
- Back-to-back: with run held at 1, T0 of the next instruction immediately follows the final step; there are no idle cycles.
- Reset behaviour:
  - While clear=1, every output is forced to 0 in the same cycle, in any state.
  - The state becomes IDLE on the next edge; busy=0 after reset.
- Reset mid-instruction abandons the instruction with no further strobes. Any datapath writes already strobed remain.
- clear and run both high: clear wins.

## Configuration
- MULDIV_EN defined: opcodes 01111 and 10000 run the 7-cycle MUL/DIV sequence, and the MUL, DIV, Zhighin, Zhighout, HIin and LOin ports are driven.
- MULDIV_EN undefined:
  - 01111 and 10000 are illegal opcodes and take the 4-cycle path with an illegal pulse.
  - MUL, DIV, Zhighin, Zhighout, HIin and LOin remain ports, tied to 0.

## Test plan
- **ADD:** clear for 1 cycle, then run=1, ir=0x18918000 (add R1,R2,R3).
  - T3: Rout=0x0004, Yin=1.
  - T4: Rout=0x0008, ADD=1, Zlowin=1.
  - T5: Zlowout=1, Rin=0x0002.
  - Next cycle: T0 with PCout=1.
- **MUL (MULDIV_EN defined):** ir=0x80228000 (mul rb=R4, rc=R5).
  - T3: Rout=0x0010, Yin=1.
  - T4: Rout=0x0020, MUL=1, Zlowin=1, Zhighin=1.
  - T5: LOin=1. T6: HIin=1.
  - 7 cycles total.
- **NEG:** ir=0x8BB00000 (neg R7,R6).
  - T3: Rout=0x0040, NEG=1, Zlowin=1.
  - T4: Zlowout=1, Rin=0x0080.
  - Then T0.
- **Illegal opcode and stop:** ir=0xF8000000, with run dropped to 0 during T2.
  - T3: illegal=1, Rin=0, Rout=0.
  - Next state IDLE, busy=0.
- **Reset mid-instruction:** clear=1 in T4 of an ADD.
  - Same cycle: all outputs 0.
  - Next edge: IDLE; R1 strobe (Rin=0x0002) never asserted.
- **MULDIV_EN undefined:** ir=0x80228000.
  - T3: illegal=1.
  - MUL, HIin and LOin never asserted.
